// File: rtl/ifft_to_codec_buffer.sv
// Ping-pong frame buffer from the post-IFFT rescaler to the audio codec.
// Define UNDERRUN_HOLD_EN to repeat the last played sample on underrun instead of zero.
module ifft_to_codec_buffer #(
    parameter int LOG_DEPTH  = 9,
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic [LOG_DEPTH-1:0]  in_index,
    input  logic                  sample_req,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  underrun,
    output logic                  overflow,
    output logic                  play_bank
);
    localparam logic [LOG_DEPTH-1:0] LAST_INDEX = '1;

    logic [DATA_WIDTH-1:0] mem [2**(LOG_DEPTH+1)];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [1:0]            full;
    logic [1:0]            full_set;
    logic [1:0]            full_clr;
    logic [LOG_DEPTH-1:0]  rd_ptr;
    logic                  rd_pending;
    logic                  rd_hit;
    logic                  wr_fire;
    logic                  wr_close;
    logic                  rd_accept;
    logic                  rd_fire;

    assign wr_fire   = in_valid && !full[wr_bank];
    assign wr_close  = wr_fire && (in_index == LAST_INDEX);
    assign rd_accept = sample_req && !rd_pending;
    assign rd_fire   = rd_accept && full[rd_bank];
    assign play_bank = rd_bank;

    // Writer only closes an empty bank and reader only frees a full one, so set and clear never collide.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_close) begin
            full_set[wr_bank] = 1'b1;
        end
        if (rd_fire && (rd_ptr == LAST_INDEX)) begin
            full_clr[rd_bank] = 1'b1;
        end
    end

    // NOTE: the RAM and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[{wr_bank, in_index}] <= in_data;
        end
        rd_word <= mem[{rd_bank, rd_ptr}];
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full       <= 2'b00;
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
            rd_hit     <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            underrun   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            full       <= (full & ~full_clr) | full_set;
            overflow   <= in_valid && full[wr_bank];
            underrun   <= rd_accept && !full[rd_bank];
            rd_pending <= rd_accept;
            rd_hit     <= rd_fire;
            out_valid  <= rd_pending;

            if (wr_close) begin
                wr_bank <= ~wr_bank;
            end

            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (rd_ptr == LAST_INDEX) begin
                    rd_bank <= ~rd_bank;
                end
            end

            // Second read stage: RAM word lands here one cycle after the request was accepted.
            if (rd_pending) begin
                if (rd_hit) begin
                    out_data <= rd_word;
                end else begin
`ifdef UNDERRUN_HOLD_EN
                    out_data <= out_data;
`else
                    out_data <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ifft_to_codec_buffer.sv
// Scoreboard bench for ifft_to_codec_buffer: a frame-FIFO reference model predicts every output pulse.
module tb_ifft_to_codec_buffer;
    localparam int LOG_DEPTH  = 3;
    localparam int DATA_WIDTH = 18;
    localparam int DEPTH      = 1 << LOG_DEPTH;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [DATA_WIDTH-1:0] in_data = '0;
    logic                  in_valid = 1'b0;
    logic [LOG_DEPTH-1:0]  in_index = '0;
    logic                  sample_req = 1'b0;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  underrun;
    logic                  overflow;
    logic                  play_bank;

    ifft_to_codec_buffer #(.LOG_DEPTH(LOG_DEPTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_index(in_index), .sample_req(sample_req), .out_data(out_data),
        .out_valid(out_valid), .underrun(underrun), .overflow(overflow),
        .play_bank(play_bank)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: completed frames are a sample FIFO; bank contents persist for stale indices.
    typedef struct { int due; logic [DATA_WIDTH-1:0] data; } out_exp_t;
    out_exp_t              out_q[$];
    int                    und_q[$];
    int                    ovf_q[$];
    logic [DATA_WIDTH-1:0] ready_q[$];
    logic [DATA_WIDTH-1:0] m_mem [2][DEPTH];
    int                    m_wr_bank = 0;
    int                    played = 0;
    logic [DATA_WIDTH-1:0] m_last = '0;

    // Inputs are applied 1 time unit after a rising edge and sampled on the next one.
    task automatic step(input logic v, input int idx, input logic [DATA_WIDTH-1:0] d, input logic req);
        bit       starve;
        bit       drop;
        out_exp_t e;
        in_valid   = v;
        in_index   = LOG_DEPTH'(idx);
        in_data    = d;
        sample_req = req;
        starve = (ready_q.size() == 0);
        drop   = (ready_q.size() > DEPTH);
        if (req) begin
            e.due = cyc + 2;
            if (starve) begin
                und_q.push_back(cyc + 1);
`ifdef UNDERRUN_HOLD_EN
                e.data = m_last;
`else
                e.data = '0;
`endif
            end else begin
                e.data = ready_q.pop_front();
                m_last = e.data;
                played++;
            end
            out_q.push_back(e);
        end
        if (v) begin
            if (drop) begin
                ovf_q.push_back(cyc + 1);
            end else begin
                m_mem[m_wr_bank][idx] = d;
                if (idx == DEPTH - 1) begin
                    for (int i = 0; i < DEPTH; i++) ready_q.push_back(m_mem[m_wr_bank][i]);
                    m_wr_bank = 1 - m_wr_bank;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, '0, 1'b0);
    endtask

    task automatic write_frame(input int base);
        for (int i = 0; i < DEPTH; i++) step(1'b1, i, DATA_WIDTH'(base + i), 1'b0);
    endtask

    task automatic play(input int n, input int gap);
        repeat (n) begin
            step(1'b0, 0, '0, 1'b1);
            idle(gap);
            check("play_bank", 64'(play_bank), 64'((played / DEPTH) % 2));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"},  64'(out_data),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_underrun"},  64'(underrun),  64'd0);
        check({tag, "_overflow"},  64'(overflow),  64'd0);
        check({tag, "_play_bank"}, 64'(play_bank), 64'd0);
    endtask

    // Monitor: every pulse on an output must match the head of its expectation queue in that cycle.
    always @(negedge clock) begin : monitor
        bit       e;
        out_exp_t x;
        if (!reset) begin
            e = (out_q.size() > 0) && (out_q[0].due == cyc);
            if (out_valid || e) begin
                check("out_valid", 64'(out_valid), 64'(e));
                if (e) begin
                    x = out_q.pop_front();
                    check("out_data", 64'(out_data), 64'(x.data));
                end
            end
            e = (und_q.size() > 0) && (und_q[0] == cyc);
            if (underrun || e) begin
                check("underrun", 64'(underrun), 64'(e));
                if (e) void'(und_q.pop_front());
            end
            e = (ovf_q.size() > 0) && (ovf_q[0] == cyc);
            if (overflow || e) begin
                check("overflow", 64'(overflow), 64'(e));
                if (e) void'(ovf_q.pop_front());
            end
        end
    end

    initial begin
        int guard;
        int next_idx;
        int last_req;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        // In-order frame 100..107, played with 10-cycle strobe spacing.
        write_frame(100);
        play(DEPTH, 9);

        // Empty buffer: underrun at +1, zero (or held sample) at +2.
        play(2, 4);

        // Two full frames, third frame dropped sample by sample.
        write_frame(0);
        write_frame(8);
        write_frame(900);
        play(2 * DEPTH, 3);

        // Reverse-order writes: index 7 closes a bank holding stale data; 6..0 land in the other bank.
        for (int i = DEPTH - 1; i >= 0; i--) step(1'b1, i, DATA_WIDTH'(200 + i), 1'b0);
        play(DEPTH, 3);
        step(1'b1, DEPTH - 1, DATA_WIDTH'(217), 1'b0);
        play(DEPTH, 3);

        // Same-cycle frame close on one bank and final read on the other.
        write_frame(300);
        play(DEPTH - 1, 3);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, i, DATA_WIDTH'(400 + i), 1'b0);
        step(1'b1, DEPTH - 1, DATA_WIDTH'(407), 1'b1);
        idle(3);
        write_frame(450);
        play(2 * DEPTH, 3);

        // Asynchronous reset mid-playback of the second bank.
        write_frame(500);
        write_frame(600);
        play(DEPTH + 4, 3);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        out_q.delete();
        und_q.delete();
        ovf_q.delete();
        ready_q.delete();
        m_wr_bank = 0;
        played    = 0;
        m_last    = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        play(1, 3);
        step(1'b1, DEPTH - 1, DATA_WIDTH'(700), 1'b0);
        play(DEPTH, 3);

        // Randomized traffic: mostly sequential frames with scattered indices and spaced strobes.
        next_idx = 0;
        last_req = -10;
        repeat (800) begin
            logic                  v;
            logic                  r;
            int                    idx;
            logic [DATA_WIDTH-1:0] d;
            v   = ($urandom_range(2) != 0);
            idx = ($urandom_range(7) == 0) ? int'($urandom_range(DEPTH - 1)) : next_idx;
            if (v && idx == next_idx) next_idx = (next_idx + 1) % DEPTH;
            r = ((cyc - last_req) >= 3) && ($urandom_range(1) == 0);
            if (r) last_req = cyc;
            d = DATA_WIDTH'($urandom);
            step(v, idx, d, r);
        end

        guard = 0;
        while ((out_q.size() + und_q.size() + ovf_q.size()) != 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        check("drain", 64'(out_q.size() + und_q.size() + ovf_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
